scale_step_ctrl: RTL and testbench

//  Sequencer for the 6-bit frequency Scale that feeds the Divider/Sum waveform path.

---
 rtl/scale_step_ctrl_if.sv | 21 ++
 rtl/scale_step_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_scale_step_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scale_step_ctrl_if.sv
// Button/sweep controls and Scale status between the debouncers and Sum.
interface scale_step_ctrl_if;
  logic       Bt_Plus;
  logic       Bt_Minus;
  logic       Sweep_En;
  logic [5:0] Scale;
  logic       Scale_Upd;
  logic       At_Max;
  logic       At_Min;
  logic       Sweep_Dir;

  modport master (
    output Bt_Plus, Bt_Minus, Sweep_En,
    input  Scale, Scale_Upd, At_Max, At_Min, Sweep_Dir
  );

  modport slave (
    input  Bt_Plus, Bt_Minus, Sweep_En,
    output Scale, Scale_Upd, At_Max, At_Min, Sweep_Dir
  );
endinterface

// File: rtl/scale_step_ctrl.sv
// Scale sequencer: single step on press, hold-to-repeat, triangle sweep.
module scale_step_ctrl #(
  parameter int SCALE_MIN  = 0,
  parameter int SCALE_MAX  = 63,
  parameter int SCALE_RST  = 8,
  parameter int HOLD_CYC   = 5000000,
  parameter int REPEAT_CYC = 1000000,
  parameter int SWEEP_CYC  = 2000000
) (
  input logic           sysclk,
  input logic           reset,
  scale_step_ctrl_if.slave bus
);

  localparam int HR_MAX  = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_MAX = (HR_MAX > SWEEP_CYC) ? HR_MAX : SWEEP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_CYC - 1);
  localparam logic [CW-1:0] SWEEP_LAST = CW'(SWEEP_CYC - 1);

  localparam logic [5:0] S_MIN = 6'(SCALE_MIN);
  localparam logic [5:0] S_MAX = 6'(SCALE_MAX);
  localparam logic [5:0] S_RST = 6'(SCALE_RST);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, SWEEP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    scale_q, scale_d;
  logic          upd_q, upd_d;
  logic          dir_q, dir_d;
  logic          at_max_q, at_max_d;
  logic          at_min_q, at_min_d;
  logic          up_q, up_d;
  logic          armed_q, armed_d;
  logic          plus_prev_q, plus_prev_d;
  logic          minus_prev_q, minus_prev_d;

  logic       plus_rise, minus_rise, both, any, press_hi;
  logic       do_step, step_up, sweep_step;
  logic [5:0] step_val;

  // armed_q hides the first cycle after reset so a held button is no edge
  assign plus_rise  = armed_q & bus.Bt_Plus & ~plus_prev_q;
  assign minus_rise = armed_q & bus.Bt_Minus & ~minus_prev_q;
  assign both       = bus.Bt_Plus & bus.Bt_Minus;
  assign any        = bus.Bt_Plus | bus.Bt_Minus;
  assign press_hi   = up_q ? bus.Bt_Plus : bus.Bt_Minus;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scale_d      = scale_q;
    upd_d        = 1'b0;
    dir_d        = dir_q;
    up_d         = up_q;
    armed_d      = 1'b1;
    plus_prev_d  = bus.Bt_Plus;
    minus_prev_d = bus.Bt_Minus;
    do_step      = 1'b0;
    step_up      = 1'b0;
    sweep_step   = 1'b0;
    step_val     = scale_q;

    if (both) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (plus_rise | minus_rise) begin
            do_step = 1'b1;
            step_up = plus_rise;
            up_d    = plus_rise;
            state_d = HOLD;
            cnt_d   = '0;
          end else if (bus.Sweep_En && !any) begin
            state_d = SWEEP;
            cnt_d   = '0;
          end
        end
        HOLD: begin
          if (!press_hi) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_LAST) begin
            do_step = 1'b1;
            step_up = up_q;
            state_d = REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!press_hi) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == REP_LAST) begin
            do_step = 1'b1;
            step_up = up_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SWEEP: begin
          if (any) begin
            // keep history so IDLE still sees this press as a rising edge
            state_d      = IDLE;
            cnt_d        = '0;
            plus_prev_d  = plus_prev_q;
            minus_prev_d = minus_prev_q;
          end else if (!bus.Sweep_En) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == SWEEP_LAST) begin
            do_step    = 1'b1;
            step_up    = dir_q;
            sweep_step = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    if (step_up) begin
      step_val = (scale_q >= S_MAX) ? scale_q : scale_q + 6'd1;
    end else begin
      step_val = (scale_q <= S_MIN) ? scale_q : scale_q - 6'd1;
    end

    if (do_step) begin
      scale_d = step_val;
      upd_d   = (step_val != scale_q);
    end

    if (sweep_step) begin
      if (step_up && step_val == S_MAX) dir_d = 1'b0;
      if (!step_up && step_val == S_MIN) dir_d = 1'b1;
    end

    at_max_d = (scale_d == S_MAX);
    at_min_d = (scale_d == S_MIN);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      scale_q      <= S_RST;
      upd_q        <= 1'b0;
      dir_q        <= 1'b1;
      at_max_q     <= (S_RST == S_MAX);
      at_min_q     <= (S_RST == S_MIN);
      up_q         <= 1'b0;
      armed_q      <= 1'b0;
      plus_prev_q  <= 1'b0;
      minus_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scale_q      <= scale_d;
      upd_q        <= upd_d;
      dir_q        <= dir_d;
      at_max_q     <= at_max_d;
      at_min_q     <= at_min_d;
      up_q         <= up_d;
      armed_q      <= armed_d;
      plus_prev_q  <= plus_prev_d;
      minus_prev_q <= minus_prev_d;
    end
  end

  assign bus.Scale     = scale_q;
  assign bus.Scale_Upd = upd_q;
  assign bus.At_Max    = at_max_q;
  assign bus.At_Min    = at_min_q;
  assign bus.Sweep_Dir = dir_q;

endmodule

// File: tb/tb_scale_step_ctrl.sv
// Bench for scale_step_ctrl: vector table, corner sequences, random vs model.
module tb_scale_step_ctrl;

  localparam int HOLD = 4;
  localparam int REP  = 2;
  localparam int SWP  = 3;
  localparam int RSTV = 8;
  localparam int MINV = 0;
  localparam int MAXV = 63;

  logic sysclk = 1'b0;
  logic reset;

  scale_step_ctrl_if bus();

  scale_step_ctrl #(
    .SCALE_MIN(MINV), .SCALE_MAX(MAXV), .SCALE_RST(RSTV),
    .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .SWEEP_CYC(SWP)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic m, input logic en);
    bus.Bt_Plus  = p;
    bus.Bt_Minus = m;
    bus.Sweep_En = en;
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic chk_rst(input string name);
    chk({name, "_scale"}, 32'(bus.Scale), RSTV);
    chk({name, "_upd"}, 32'(bus.Scale_Upd), 0);
    chk({name, "_dir"}, 32'(bus.Sweep_Dir), 1);
    chk({name, "_atmax"}, 32'(bus.At_Max), 0);
    chk({name, "_atmin"}, 32'(bus.At_Min), 0);
  endtask

  // Reference model: press timing from elapsed cycles since the press
  int m_scale, m_mode, m_t0, m_cyc;
  bit m_dir, m_up, m_upd, m_pp, m_pm, m_armed;

  function automatic void m_reset();
    m_scale = RSTV; m_mode = 0; m_t0 = 0; m_cyc = 0;
    m_dir = 1; m_up = 0; m_upd = 0;
    m_pp = 0; m_pm = 0; m_armed = 0;
  endfunction

  function automatic void m_move(input bit up, input bit sweep);
    int n;
    n = up ? m_scale + 1 : m_scale - 1;
    if (n > MAXV) n = MAXV;
    if (n < MINV) n = MINV;
    m_upd = (n != m_scale);
    m_scale = n;
    if (sweep && up && n == MAXV) m_dir = 0;
    if (sweep && !up && n == MINV) m_dir = 1;
  endfunction

  function automatic void m_step(input bit p, input bit m, input bit en);
    bit rp, rm, keep;
    int k;
    m_upd = 0;
    keep = 0;
    rp = m_armed && p && !m_pp;
    rm = m_armed && m && !m_pm;
    k = m_cyc - m_t0;
    if (p && m) m_mode = 0;
    else if (m_mode == 0) begin
      if (rp || rm) begin
        m_up = rp; m_move(rp, 0); m_mode = 1; m_t0 = m_cyc;
      end else if (en && !p && !m) begin
        m_mode = 2; m_t0 = m_cyc;
      end
    end else if (m_mode == 1) begin
      if (!(m_up ? p : m)) m_mode = 0;
      else if (k == HOLD || (k > HOLD && (k - HOLD) % REP == 0))
        m_move(m_up, 0);
    end else begin
      if (p || m || !en) begin
        m_mode = 0; keep = p || m;
      end else if (k % SWP == 0) m_move(m_dir, 1);
    end
    if (!keep) begin m_pp = p; m_pm = m; end
    m_armed = 1;
    m_cyc++;
  endfunction

  typedef struct {
    bit p;
    bit m;
    int s;
    bit u;
  } vec_t;

  vec_t tv[22];
  int   sq[4];

  initial begin
    bit rp, rm, ren;

    tv[0]  = '{1, 0, 9, 1};  tv[1]  = '{0, 0, 9, 0};
    tv[2]  = '{0, 0, 9, 0};  tv[3]  = '{0, 1, 8, 1};
    tv[4]  = '{0, 1, 8, 0};  tv[5]  = '{0, 1, 8, 0};
    tv[6]  = '{0, 1, 8, 0};  tv[7]  = '{0, 1, 7, 1};
    tv[8]  = '{0, 1, 7, 0};  tv[9]  = '{0, 1, 6, 1};
    tv[10] = '{0, 1, 6, 0};  tv[11] = '{0, 1, 5, 1};
    tv[12] = '{0, 0, 5, 0};  tv[13] = '{0, 0, 5, 0};
    tv[14] = '{1, 1, 5, 0};  tv[15] = '{1, 0, 5, 0};
    tv[16] = '{1, 0, 5, 0};  tv[17] = '{0, 0, 5, 0};
    tv[18] = '{1, 0, 6, 1};  tv[19] = '{1, 1, 6, 0};
    tv[20] = '{1, 0, 6, 0};  tv[21] = '{0, 0, 6, 0};
    sq[0] = 62; sq[1] = 63; sq[2] = 62; sq[3] = 61;

    bus.Bt_Plus = 0; bus.Bt_Minus = 0; bus.Sweep_En = 0;
    reset = 1;
    @(negedge sysclk);
    @(negedge sysclk);
    chk_rst("reset");
    reset = 0;
    cyc(0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      cyc(tv[i].p, tv[i].m, 1'b0);
      chk($sformatf("vec%0d_scale", i), 32'(bus.Scale), tv[i].s);
      chk($sformatf("vec%0d_upd", i), 32'(bus.Scale_Upd), 32'(tv[i].u));
    end

    for (int i = 0; i < 140; i++) cyc(1, 0, 0);
    chk("hold_to_max", 32'(bus.Scale), MAXV);
    chk("at_max", 32'(bus.At_Max), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0);
      chk("sat_max_scale", 32'(bus.Scale), MAXV);
      chk("sat_max_upd", 32'(bus.Scale_Upd), 0);
    end
    chk("sat_max_flag", 32'(bus.At_Max), 1);
    cyc(0, 0, 0);

    cyc(0, 1, 0);
    chk("tap_62", 32'(bus.Scale), 62);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("tap_61", 32'(bus.Scale), 61);
    chk("tap_atmax", 32'(bus.At_Max), 0);
    cyc(0, 0, 0);

    cyc(0, 0, 1);
    chk("sweep_entry", 32'(bus.Scale), 61);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 1);
      chk($sformatf("sweep%0d_scale", k), 32'(bus.Scale),
          sq[(k / 3 > 0) ? (k / 3 - 1) : 0] * ((k >= 3) ? 1 : 0)
          + ((k < 3) ? 61 : 0));
      chk($sformatf("sweep%0d_upd", k), 32'(bus.Scale_Upd),
          (k % 3 == 0) ? 1 : 0);
      chk($sformatf("sweep%0d_dir", k), 32'(bus.Sweep_Dir),
          (k >= 6) ? 0 : 1);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0);
      chk("freeze_scale", 32'(bus.Scale), 61);
      chk("freeze_upd", 32'(bus.Scale_Upd), 0);
    end
    chk("freeze_dir", 32'(bus.Sweep_Dir), 0);

    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    chk("sweep_moved", 32'(bus.Scale), 60);
    #2 reset = 1;
    #1 chk_rst("rst_sweep");
    bus.Sweep_En = 0;
    @(negedge sysclk);
    reset = 0;
    cyc(0, 0, 0);

    for (int i = 0; i < 40; i++) cyc(0, 1, 0);
    chk("hold_to_min", 32'(bus.Scale), MINV);
    chk("at_min", 32'(bus.At_Min), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0);
      chk("sat_min_scale", 32'(bus.Scale), MINV);
      chk("sat_min_upd", 32'(bus.Scale_Upd), 0);
    end
    chk("sat_min_flag", 32'(bus.At_Min), 1);
    cyc(0, 0, 0);

    for (int i = 0; i < 8; i++) cyc(1, 0, 0);
    chk("repeat_reached", 32'(bus.Scale), 3);
    #2 reset = 1;
    #1 chk_rst("rst_repeat");
    @(negedge sysclk);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      chk("held_after_rst", 32'(bus.Scale), RSTV);
      chk("held_after_rst_upd", 32'(bus.Scale_Upd), 0);
    end
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("new_edge_scale", 32'(bus.Scale), RSTV + 1);
    chk("new_edge_upd", 32'(bus.Scale_Upd), 1);
    cyc(0, 0, 0);

    reset = 1;
    bus.Bt_Plus = 0; bus.Bt_Minus = 0; bus.Sweep_En = 0;
    @(negedge sysclk);
    reset = 0;
    m_reset();
    rp = 0; rm = 0; ren = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rp) rp = ($urandom_range(0, 11) != 0);
      else rp = ($urandom_range(0, 39) == 0);
      if (rm) rm = ($urandom_range(0, 11) != 0);
      else rm = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) ren = !ren;
      m_step(rp, rm, ren);
      cyc(rp, rm, ren);
      chk("rnd_scale", 32'(bus.Scale), m_scale);
      chk("rnd_upd", 32'(bus.Scale_Upd), 32'(m_upd));
      chk("rnd_dir", 32'(bus.Sweep_Dir), 32'(m_dir));
      chk("rnd_atmax", 32'(bus.At_Max), (m_scale == MAXV) ? 1 : 0);
      chk("rnd_atmin", 32'(bus.At_Min), (m_scale == MINV) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
